mod_dcache_lru: RTL
===================

# mod_dcache_lru

Parametrised N-way set-associative, write-back, write-allocate L1 data cache with true-LRU replacement, word-granular byte-enabled accesses and an explicit line-flush operation. It sits between the core's data-memory port and the cache/memory arbiter. It replaces the fixed 4-way, whole-block, evict-way-0 data cache. Tag and data storage are internal register arrays: one line per way per set.

## Interface
Parameters:
- WORDSIZE, 64, core data word width in bits; byte enables are WORDSIZE/8 wide.
- ADDRW, 64, address width.
- LOGLINE, 6, log2 of line size in bytes; line = 8·2^LOGLINE bits.
- LOGSETS, 7, log2 of the number of sets.
- LOGWAYS, 2, log2 of associativity; LOGWAYS=0 gives a direct-mapped cache.
- TAGWIDTH, 13, width of the request tag passed through to the response.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- core_reqcyc  in  1  request valid.
- core_reqack  out  1  one-cycle accept pulse.
- core_req  in  ADDRW  byte address; bits [log2(WORDSIZE/8)-1:0] are ignored.
- core_reqop  in  2  operation: 0 = read, 1 = write, 2 = flush line; 3 is reserved and is treated as a flush.
- core_reqtag  in  TAGWIDTH  opaque tag.
- core_reqdata  in  WORDSIZE  write data.
- core_reqbe  in  WORDSIZE/8  byte enables (write only).
- core_respcyc  out  1  one-cycle response pulse.
- core_resptag  out  TAGWIDTH  echo of core_reqtag.
- core_resp  out  WORDSIZE  read data; 0 for writes and flushes.
- mem_reqcyc  out  1  memory request valid.
- mem_reqack  in  1  memory accept.
- mem_req  out  ADDRW  line-aligned address.
- mem_reqwrite  out  1  1 = write-back, 0 = fill.
- mem_reqdata  out  line  write-back data.
- mem_respcyc  in  1  memory response valid.
- mem_resp  out-of-cache direction: in  line  fill data.
- mem_respack  out  1  combinational copy of mem_respcyc.

## Operation
Address split: offset = [LOGLINE-1:0]; word select = the offset bits above the byte-in-word bits; index = [LOGLINE+LOGSETS-1:LOGLINE]; tag = the bits above index.

States and transitions:
- IDLE: if core_reqcyc=1, latch the request and go to LOOKUP.
- LOOKUP: compare the tag against every valid way of the set.
  - Read hit: respond with the selected word.
  - Write hit: merge the enabled bytes, set dirty, respond.
  - Flush hit: if clean, invalidate and respond; if dirty, go to WB_REQ and invalidate after the write-back.
  - Flush miss: respond.
  - Read/write miss: pick the victim. If the victim is valid and dirty, go to WB_REQ; otherwise go to FILL_REQ.
- WB_REQ: drive mem_reqcyc with mem_reqwrite=1, mem_req = {victim tag, index, 0}, and mem_reqdata = victim line. Go to WB_WAIT.
- WB_WAIT: wait for mem_respcyc. Then a flush invalidates the line and responds; a miss goes to FILL_REQ.
- FILL_REQ: drive mem_reqcyc with mem_reqwrite=0 and mem_req = line address. Go to FILL_WAIT.
- FILL_WAIT: on mem_respcyc, install the line with valid=1 and the new tag. For a write, merge the enabled bytes into the fetched line and set dirty=1; for a read, dirty=0. Then respond.
- RESPOND: pulse core_respcyc for one cycle, return to IDLE.

Replacement:
- The victim is the lowest-index invalid way; if all ways are valid, the way whose age = 2^LOGWAYS−1.
- LRU update on every read or write hit and every fill: the accessed way's age becomes 0; ways with age less than its old age increment by 1.
- Flush does not touch ages.

Reset:
- All valid and dirty bits clear.
- The age of way w in every set = w.
- State = IDLE.
- All outputs 0; mem_respack still follows mem_respcyc.

## Timing
- Request sampled at edge T in IDLE. core_reqack=1 during cycle T+1, otherwise 0.
- Hit or flush-clean/miss: core_respcyc=1 during cycle T+2.
- Misses add the memory latency. mem_reqcyc stays high until mem_reqack is sampled 1, then drops the next cycle. mem_req, mem_reqwrite and mem_reqdata are stable while mem_reqcyc=1.
- core_reqcyc is ignored outside IDLE: no reqack and no side effects.
- mem_respcyc is ignored outside WB_WAIT and FILL_WAIT.
- mem_respcyc arriving in the same cycle as mem_reqack is legal and completes the transaction.
- Reset mid-operation: on the next cycle state = IDLE and all outputs are 0. The outstanding memory transaction is abandoned, and any line being filled stays invalid.
- core_resp, core_resptag and core_respcyc update together and hold only for the pulse cycle.

## Test plan
- After reset, read 0x1000 → mem fill request at 0x1000 with mem_reqwrite=0. Return a line with word0=0xAAAA_AAAA_AAAA_AAAA → core_resp=0xAAAA_AAAA_AAAA_AAAA. A read of 0x1000 again → respcyc at T+2 with no mem_reqcyc.
- After the line is present, write 0x1008 with data 0x1122334455667788 and be=0x0F → hit, no memory traffic. Reading 0x1008 → the low 4 bytes read 0x55667788 and the upper bytes are unchanged.
- Access 0x0000, 0x2000, 0x4000, 0x6000 (all index 0), then 0x0000, then 0x8000 → the fill of 0x8000 evicts 0x2000. A read of 0x2000 then misses; a read of 0x0000 hits.
- Write 0x4000 (dirty), then fill tags until 0x4000 is the LRU way, then miss → mem write-back to 0x4000 with the merged data before the fill request.
- Flush a dirty 0x4000 → write-back to 0x4000, then respcyc; a later read of 0x4000 misses. Flush of an absent 0x9000 → respcyc at T+2 with no memory traffic.
- Assert reset in FILL_WAIT → the next cycle has all outputs 0. A later read of the same address issues a new fill.

Source files
------------

// File: rtl/mod_dcache_lru.sv
// mod_dcache_lru
// N-way set-associative, write-back, write-allocate L1 data cache with
// true-LRU replacement, byte-enabled word accesses and a line-flush operation.
// Tag, data, valid, dirty and age storage are internal register arrays.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   core_reqcyc/core_reqack     request valid / one-cycle accept pulse
//   core_req, core_reqop        byte address, op (0 rd, 1 wr, 2/3 flush)
//   core_reqtag/data/be         opaque tag, write data, byte enables
//   core_respcyc/resptag/resp   one-cycle response pulse, tag echo, read data
//   mem_reqcyc/reqack           memory request valid / accept
//   mem_req/reqwrite/reqdata    line address, 1 = write-back, victim line
//   mem_respcyc/resp/respack    memory response valid, fill line, ack copy
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for core_reqcyc, latch request
// S_LOOKUP    | tag compare, hit handling, victim selection
// S_WB_REQ    | write-back request held until mem_reqack
// S_WB_WAIT   | waiting for write-back completion
// S_FILL_REQ  | fill request held until mem_reqack
// S_FILL_WAIT | waiting for fill data, then install line
// S_RESPOND   | one-cycle core response pulse
module mod_dcache_lru #(
  parameter int WORDSIZE = 64,
  parameter int ADDRW    = 64,
  parameter int LOGLINE  = 6,
  parameter int LOGSETS  = 7,
  parameter int LOGWAYS  = 2,
  parameter int TAGWIDTH = 13
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_reqcyc,
  output logic                         core_reqack,
  input  logic [ADDRW-1:0]             core_req,
  input  logic [1:0]                   core_reqop,
  input  logic [TAGWIDTH-1:0]          core_reqtag,
  input  logic [WORDSIZE-1:0]          core_reqdata,
  input  logic [WORDSIZE/8-1:0]        core_reqbe,
  output logic                         core_respcyc,
  output logic [TAGWIDTH-1:0]          core_resptag,
  output logic [WORDSIZE-1:0]          core_resp,
  output logic                         mem_reqcyc,
  input  logic                         mem_reqack,
  output logic [ADDRW-1:0]             mem_req,
  output logic                         mem_reqwrite,
  output logic [8*(1<<LOGLINE)-1:0]    mem_reqdata,
  input  logic                         mem_respcyc,
  input  logic [8*(1<<LOGLINE)-1:0]    mem_resp,
  output logic                         mem_respack
);

  localparam int NBE   = WORDSIZE / 8;
  localparam int BOFF  = $clog2(NBE);
  localparam int WSELW = LOGLINE - BOFF;
  localparam int LINEW = 8 * (1 << LOGLINE);
  localparam int NWAYS = 1 << LOGWAYS;
  localparam int NSETS = 1 << LOGSETS;
  localparam int AW    = (LOGWAYS > 0) ? LOGWAYS : 1;
  localparam int TW    = ADDRW - LOGLINE - LOGSETS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT, S_RESPOND
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]       tag_mem  [NSETS][NWAYS];
  logic [LINEW-1:0]    data_mem [NSETS][NWAYS];
  logic [NWAYS-1:0]    valid_q  [NSETS];
  logic [NWAYS-1:0]    dirty_q  [NSETS];
  logic [AW-1:0]       age_q    [NSETS][NWAYS];

  logic [TW-1:0]       req_tag_q;
  logic [LOGSETS-1:0]  req_idx_q;
  logic [WSELW-1:0]    req_wsel_q;
  logic [1:0]          req_op_q;
  logic [TAGWIDTH-1:0] req_rtag_q;
  logic [WORDSIZE-1:0] req_data_q;
  logic [NBE-1:0]      req_be_q;
  logic [AW-1:0]       sel_way_q;
  logic [WORDSIZE-1:0] resp_data_q;

  logic                hit;
  logic [AW-1:0]       hit_way;
  logic [AW-1:0]       victim_way;
  logic                victim_found;
  logic                is_flush, is_write, is_read;
  logic                lookup_hit_rw, wb_done, fill_done, lru_touch;
  logic [AW-1:0]       lru_way;
  logic [LINEW-1:0]    hit_line;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^core_req[BOFF-1:0];

  function automatic logic [LINEW-1:0] merge_word(
    input logic [LINEW-1:0]    line,
    input logic [WSELW-1:0]    wsel,
    input logic [WORDSIZE-1:0] wd,
    input logic [NBE-1:0]      be
  );
    logic [LINEW-1:0] r;
    r = line;
    for (int b = 0; b < NBE; b++) begin
      if (be[b]) r[int'(wsel)*WORDSIZE + b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [WORDSIZE-1:0] get_word(
    input logic [LINEW-1:0] line,
    input logic [WSELW-1:0] wsel
  );
    return line[int'(wsel)*WORDSIZE +: WORDSIZE];
  endfunction

  assign is_flush = req_op_q[1];
  assign is_write = (req_op_q == 2'd1);
  assign is_read  = (req_op_q == 2'd0);

  // Hit detect picks the lowest matching way; the victim is the lowest
  // invalid way, else the way holding the oldest age.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!hit && valid_q[req_idx_q][w] && (tag_mem[req_idx_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = 0; w < NWAYS; w++) begin
      if (!victim_found && !valid_q[req_idx_q][w]) begin
        victim_found = 1'b1;
        victim_way   = AW'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (age_q[req_idx_q][w] == AW'(NWAYS-1)) victim_way = AW'(w);
      end
    end
  end

  assign hit_line      = data_mem[req_idx_q][hit_way];
  assign lookup_hit_rw = (state == S_LOOKUP) && hit && !is_flush;
  // A response arriving together with the accept completes the transaction.
  assign wb_done   = mem_respcyc && ((state == S_WB_WAIT) || ((state == S_WB_REQ) && mem_reqack));
  assign fill_done = mem_respcyc && ((state == S_FILL_WAIT) || ((state == S_FILL_REQ) && mem_reqack));
  assign lru_touch = lookup_hit_rw || fill_done;
  assign lru_way   = (state == S_LOOKUP) ? hit_way : sel_way_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    core_reqack  = 1'b0;
    core_respcyc = 1'b0;
    core_resptag = '0;
    core_resp    = '0;
    mem_reqcyc   = 1'b0;
    mem_reqwrite = 1'b0;
    mem_req      = '0;
    mem_reqdata  = '0;
    mem_respack  = mem_respcyc;
    case (state)
      S_IDLE: if (core_reqcyc) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        core_reqack = 1'b1;
        if (is_flush) begin
          state_nxt = (hit && dirty_q[req_idx_q][hit_way]) ? S_WB_REQ : S_RESPOND;
        end else if (hit) begin
          state_nxt = S_RESPOND;
        end else if (valid_q[req_idx_q][victim_way] && dirty_q[req_idx_q][victim_way]) begin
          state_nxt = S_WB_REQ;
        end else begin
          state_nxt = S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        mem_reqcyc   = 1'b1;
        mem_reqwrite = 1'b1;
        mem_req      = {tag_mem[req_idx_q][sel_way_q], req_idx_q, {LOGLINE{1'b0}}};
        mem_reqdata  = data_mem[req_idx_q][sel_way_q];
        if (wb_done)         state_nxt = is_flush ? S_RESPOND : S_FILL_REQ;
        else if (mem_reqack) state_nxt = S_WB_WAIT;
      end
      S_WB_WAIT: if (wb_done) state_nxt = is_flush ? S_RESPOND : S_FILL_REQ;
      S_FILL_REQ: begin
        mem_reqcyc = 1'b1;
        mem_req    = {req_tag_q, req_idx_q, {LOGLINE{1'b0}}};
        if (fill_done)       state_nxt = S_RESPOND;
        else if (mem_reqack) state_nxt = S_FILL_WAIT;
      end
      S_FILL_WAIT: if (fill_done) state_nxt = S_RESPOND;
      S_RESPOND: begin
        core_respcyc = 1'b1;
        core_resptag = req_rtag_q;
        core_resp    = resp_data_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line payload and tags need no reset: valid bits gate their use.
  always_ff @(posedge clk) begin
    if (lookup_hit_rw && is_write) begin
      data_mem[req_idx_q][hit_way] <= merge_word(hit_line, req_wsel_q, req_data_q, req_be_q);
    end
    if (fill_done) begin
      data_mem[req_idx_q][sel_way_q] <= is_write ?
        merge_word(mem_resp, req_wsel_q, req_data_q, req_be_q) : mem_resp;
      tag_mem[req_idx_q][sel_way_q] <= req_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NWAYS; w++) age_q[s][w] <= AW'(w);
      end
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_wsel_q  <= '0;
      req_op_q    <= '0;
      req_rtag_q  <= '0;
      req_data_q  <= '0;
      req_be_q    <= '0;
      sel_way_q   <= '0;
      resp_data_q <= '0;
    end else begin
      if (state == S_IDLE && core_reqcyc) begin
        req_tag_q  <= core_req[ADDRW-1 -: TW];
        req_idx_q  <= core_req[LOGLINE +: LOGSETS];
        req_wsel_q <= core_req[BOFF +: WSELW];
        req_op_q   <= core_reqop;
        req_rtag_q <= core_reqtag;
        req_data_q <= core_reqdata;
        req_be_q   <= core_reqbe;
      end
      if (state == S_LOOKUP) begin
        sel_way_q   <= is_flush ? hit_way : victim_way;
        resp_data_q <= (hit && is_read) ? get_word(hit_line, req_wsel_q) : '0;
        if (is_flush && hit && !dirty_q[req_idx_q][hit_way]) valid_q[req_idx_q][hit_way] <= 1'b0;
      end
      if (lookup_hit_rw && is_write) dirty_q[req_idx_q][hit_way] <= 1'b1;
      if (wb_done && is_flush) begin
        valid_q[req_idx_q][sel_way_q] <= 1'b0;
        dirty_q[req_idx_q][sel_way_q] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[req_idx_q][sel_way_q] <= 1'b1;
        dirty_q[req_idx_q][sel_way_q] <= is_write;
        resp_data_q <= is_read ? get_word(mem_resp, req_wsel_q) : '0;
      end
      // Move-to-front: accessed way becomes youngest, younger ways age by one.
      if (lru_touch) begin
        for (int w = 0; w < NWAYS; w++) begin
          if (AW'(w) == lru_way) begin
            age_q[req_idx_q][w] <= '0;
          end else if (age_q[req_idx_q][w] < age_q[req_idx_q][lru_way]) begin
            age_q[req_idx_q][w] <= age_q[req_idx_q][w] + 1'b1;
          end
        end
      end
    end
  end

endmodule
